// File: rtl/bypass_unit_pkg.sv
// Pipeline package shared by the bypass unit: stage bus structs, the
// register index width, and the common "destination matches source" test.
package bypass_unit_pkg;

    localparam int REG_AW = 5;

    typedef struct packed {
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
    } id_ex_bus_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_read;
    } ex_mem_bus_t;

    typedef struct packed {
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_to_reg;
    } mem_wb_bus_t;

    // A producer matches a consumer only if it writes a real register (x0 never forwards).
    function automatic logic reg_hit(input logic [REG_AW-1:0] rd,
                                     input logic              reg_write,
                                     input logic [REG_AW-1:0] src);
        return reg_write & (rd != '0) & (rd == src);
    endfunction

endpackage

// File: rtl/bypass_operand_sel.sv
// Forwarding select for one EX operand. MEM holds the younger value and
// wins over WB; a load sitting in MEM is never a forwarding source, so in
// that case a WB match (if any) still drives the operand.
module bypass_operand_sel
    import bypass_unit_pkg::*;
(
    input  logic [REG_AW-1:0] i_src,
    input  logic [REG_AW-1:0] i_mem_rd,
    input  logic              i_mem_reg_write,
    input  logic              i_mem_mem_read,
    input  logic [REG_AW-1:0] i_wb_rd,
    input  logic              i_wb_reg_write,
    input  logic              i_wb_mem_to_reg,
    output logic              o_from_mem,
    output logic              o_from_alu_wb,
    output logic              o_from_ld_wb
);

    logic w_mem_hit;
    logic w_wb_hit;

    // Priority-encoded one-hot-or-zero select; all zero means register-file value.
    always_comb begin
        w_mem_hit     = reg_hit(i_mem_rd, i_mem_reg_write, i_src) & ~i_mem_mem_read;
        w_wb_hit      = reg_hit(i_wb_rd, i_wb_reg_write, i_src);
        o_from_mem    = w_mem_hit;
        o_from_alu_wb = w_wb_hit & ~i_wb_mem_to_reg & ~w_mem_hit;
        o_from_ld_wb  = w_wb_hit &  i_wb_mem_to_reg & ~w_mem_hit;
    end

endmodule

// File: rtl/bypass_unit.sv
// RAW forwarding select generator for the 5-stage pipeline, plus two
// saturating counters of forwarding events (MEM-sourced and WB-sourced EX
// operands). All selects are combinational; only the counters use the clock.
// Define BYPASS_ASSERT_EN to compile simulation-only select sanity checks.
module bypass_unit
    import bypass_unit_pkg::*;
#(
    parameter int REG_AW = bypass_unit_pkg::REG_AW,
    parameter int CNT_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  id_ex_bus_t        id_ex_bus_in,
    input  ex_mem_bus_t       ex_mem_bus_in,
    input  mem_wb_bus_t       mem_wb_bus_in,
    input  logic [REG_AW-1:0] dec_rs1,
    input  logic [REG_AW-1:0] dec_rs2,
    output logic              bypassAfromMEM,
    output logic              bypassBfromMEM,
    output logic              bypassAfromALUinWB,
    output logic              bypassBfromALUinWB,
    output logic              bypassAfromLDinWB,
    output logic              bypassBfromLDinWB,
    output logic              bypassDecodeAfromWB,
    output logic              bypassDecodeBfromWB,
    output logic [CNT_W-1:0]  fwd_mem_count,
    output logic [CNT_W-1:0]  fwd_wb_count
);

    logic [CNT_W-1:0] r_fwd_mem_count;
    logic [CNT_W-1:0] r_fwd_wb_count;
    logic [1:0]       w_mem_inc;
    logic [2:0]       w_wb_inc;
    logic [CNT_W:0]   w_mem_sum;
    logic [CNT_W:0]   w_wb_sum;
    logic [CNT_W-1:0] w_mem_next;
    logic [CNT_W-1:0] w_wb_next;

    bypass_operand_sel u_sel_a (
        .i_src           (id_ex_bus_in.rs1),
        .i_mem_rd        (ex_mem_bus_in.rd),
        .i_mem_reg_write (ex_mem_bus_in.reg_write),
        .i_mem_mem_read  (ex_mem_bus_in.mem_read),
        .i_wb_rd         (mem_wb_bus_in.rd),
        .i_wb_reg_write  (mem_wb_bus_in.reg_write),
        .i_wb_mem_to_reg (mem_wb_bus_in.mem_to_reg),
        .o_from_mem      (bypassAfromMEM),
        .o_from_alu_wb   (bypassAfromALUinWB),
        .o_from_ld_wb    (bypassAfromLDinWB)
    );

    bypass_operand_sel u_sel_b (
        .i_src           (id_ex_bus_in.rs2),
        .i_mem_rd        (ex_mem_bus_in.rd),
        .i_mem_reg_write (ex_mem_bus_in.reg_write),
        .i_mem_mem_read  (ex_mem_bus_in.mem_read),
        .i_wb_rd         (mem_wb_bus_in.rd),
        .i_wb_reg_write  (mem_wb_bus_in.reg_write),
        .i_wb_mem_to_reg (mem_wb_bus_in.mem_to_reg),
        .o_from_mem      (bypassBfromMEM),
        .o_from_alu_wb   (bypassBfromALUinWB),
        .o_from_ld_wb    (bypassBfromLDinWB)
    );

    // Same-cycle register-file write/read bypass into decode; loads and ALU results alike.
    always_comb begin
        bypassDecodeAfromWB = reg_hit(mem_wb_bus_in.rd, mem_wb_bus_in.reg_write, dec_rs1);
        bypassDecodeBfromWB = reg_hit(mem_wb_bus_in.rd, mem_wb_bus_in.reg_write, dec_rs2);
    end

    // Event increments and saturating next values; the extra sum bit flags overflow.
    always_comb begin
        w_mem_inc  = {1'b0, bypassAfromMEM} + {1'b0, bypassBfromMEM};
        w_wb_inc   = {2'b00, bypassAfromALUinWB} + {2'b00, bypassBfromALUinWB}
                   + {2'b00, bypassAfromLDinWB}  + {2'b00, bypassBfromLDinWB};
        w_mem_sum  = {1'b0, r_fwd_mem_count} + {{(CNT_W-1){1'b0}}, w_mem_inc};
        w_wb_sum   = {1'b0, r_fwd_wb_count}  + {{(CNT_W-2){1'b0}}, w_wb_inc};
        w_mem_next = w_mem_sum[CNT_W] ? '1 : w_mem_sum[CNT_W-1:0];
        w_wb_next  = w_wb_sum[CNT_W]  ? '1 : w_wb_sum[CNT_W-1:0];
    end

    // Counter registers; reset wins over any increment in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_fwd_mem_count <= '0;
            r_fwd_wb_count  <= '0;
        end else begin
            r_fwd_mem_count <= w_mem_next;
            r_fwd_wb_count  <= w_wb_next;
        end
    end

    assign fwd_mem_count = r_fwd_mem_count;
    assign fwd_wb_count  = r_fwd_wb_count;

`ifdef BYPASS_ASSERT_EN
    // Simulation-only sanity checks on the select encoding.
    always @(posedge clock) begin
        if (!reset) begin
            assert ($onehot0({bypassAfromMEM, bypassAfromALUinWB, bypassAfromLDinWB}))
            else $error("%0t bypass A selects not one-hot: mem rd=%0d wb rd=%0d",
                        $time, ex_mem_bus_in.rd, mem_wb_bus_in.rd);
            assert ($onehot0({bypassBfromMEM, bypassBfromALUinWB, bypassBfromLDinWB}))
            else $error("%0t bypass B selects not one-hot: mem rd=%0d wb rd=%0d",
                        $time, ex_mem_bus_in.rd, mem_wb_bus_in.rd);
            assert (!((id_ex_bus_in.rs1 == '0) &&
                      (bypassAfromMEM | bypassAfromALUinWB | bypassAfromLDinWB)))
            else $error("%0t bypass A from x0: mem rd=%0d wb rd=%0d",
                        $time, ex_mem_bus_in.rd, mem_wb_bus_in.rd);
            assert (!((id_ex_bus_in.rs2 == '0) &&
                      (bypassBfromMEM | bypassBfromALUinWB | bypassBfromLDinWB)))
            else $error("%0t bypass B from x0: mem rd=%0d wb rd=%0d",
                        $time, ex_mem_bus_in.rd, mem_wb_bus_in.rd);
            assert (!(((dec_rs1 == '0) && bypassDecodeAfromWB) ||
                      ((dec_rs2 == '0) && bypassDecodeBfromWB)))
            else $error("%0t decode bypass from x0: mem rd=%0d wb rd=%0d",
                        $time, ex_mem_bus_in.rd, mem_wb_bus_in.rd);
        end
    end
`endif

endmodule

// File: tb/tb_bypass_unit.sv
// Directed bench for bypass_unit. Counters are built 8 bits wide so that
// saturation can be reached by simply running hits.
module tb_bypass_unit;
    import bypass_unit_pkg::*;

    localparam int CW = 8;

    logic        clock;
    logic        reset;
    id_ex_bus_t  id_ex;
    ex_mem_bus_t ex_mem;
    mem_wb_bus_t mem_wb;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic a_mem, b_mem, a_alu, b_alu, a_ld, b_ld, dec_a, dec_b;
    logic [CW-1:0] mem_cnt;
    logic [CW-1:0] wb_cnt;
    logic [5:0]    ex_sel;
    logic [1:0]    dec_sel;

    int n_cmp = 0;
    int n_err = 0;

    bypass_unit #(.REG_AW(5), .CNT_W(CW)) dut (
        .clock               (clock),
        .reset               (reset),
        .id_ex_bus_in        (id_ex),
        .ex_mem_bus_in       (ex_mem),
        .mem_wb_bus_in       (mem_wb),
        .dec_rs1             (dec_rs1),
        .dec_rs2             (dec_rs2),
        .bypassAfromMEM      (a_mem),
        .bypassBfromMEM      (b_mem),
        .bypassAfromALUinWB  (a_alu),
        .bypassBfromALUinWB  (b_alu),
        .bypassAfromLDinWB   (a_ld),
        .bypassBfromLDinWB   (b_ld),
        .bypassDecodeAfromWB (dec_a),
        .bypassDecodeBfromWB (dec_b),
        .fwd_mem_count       (mem_cnt),
        .fwd_wb_count        (wb_cnt)
    );

    // {A_MEM, A_ALUWB, A_LDWB, B_MEM, B_ALUWB, B_LDWB}
    assign ex_sel  = {a_mem, a_alu, a_ld, b_mem, b_alu, b_ld};
    assign dec_sel = {dec_a, dec_b};

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic set_nop();
        id_ex   = '0;
        ex_mem  = '0;
        mem_wb  = '0;
        dec_rs1 = '0;
        dec_rs2 = '0;
    endtask

    task automatic test_reset();
        set_nop();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        #1;
        n_cmp++;
        if (ex_sel !== 6'b0) begin
            n_err++;
            $display("FAIL reset_ex_sel got %b want %b", ex_sel, 6'b0);
        end
        n_cmp++;
        if (dec_sel !== 2'b0) begin
            n_err++;
            $display("FAIL reset_dec_sel got %b want %b", dec_sel, 2'b0);
        end
        n_cmp++;
        if (mem_cnt !== 8'd0 || wb_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_counts got mem=%0d wb=%0d want 0/0", mem_cnt, wb_cnt);
        end
    endtask

    task automatic test_mem_priority();
        set_nop();
        ex_mem = '{rd: 5'd5, reg_write: 1'b1, mem_read: 1'b0};
        mem_wb = '{rd: 5'd5, reg_write: 1'b1, mem_to_reg: 1'b0};
        id_ex  = '{rs1: 5'd5, rs2: 5'd5};
        #1;
        n_cmp++;
        if (ex_sel !== 6'b100_100) begin
            n_err++;
            $display("FAIL mem_priority_sel got %b want %b", ex_sel, 6'b100_100);
        end
        tick();
        n_cmp++;
        if (mem_cnt !== 8'd2 || wb_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL mem_priority_count got mem=%0d wb=%0d want 2/0", mem_cnt, wb_cnt);
        end
        set_nop();
    endtask

    task automatic test_load();
        set_nop();
        ex_mem = '{rd: 5'd7, reg_write: 1'b1, mem_read: 1'b1};
        mem_wb = '{rd: 5'd3, reg_write: 1'b1, mem_to_reg: 1'b1};
        id_ex  = '{rs1: 5'd7, rs2: 5'd3};
        #1;
        n_cmp++;
        if (ex_sel !== 6'b000_001) begin
            n_err++;
            $display("FAIL load_sel got %b want %b", ex_sel, 6'b000_001);
        end
        tick();
        n_cmp++;
        if (mem_cnt !== 8'd2 || wb_cnt !== 8'd1) begin
            n_err++;
            $display("FAIL load_count got mem=%0d wb=%0d want 2/1", mem_cnt, wb_cnt);
        end
        // Load in MEM and an ALU result in WB for the same register: WB drives.
        mem_wb = '{rd: 5'd7, reg_write: 1'b1, mem_to_reg: 1'b0};
        id_ex  = '{rs1: 5'd7, rs2: 5'd0};
        #1;
        n_cmp++;
        if (ex_sel !== 6'b010_000) begin
            n_err++;
            $display("FAIL load_in_mem_wb_alu_sel got %b want %b", ex_sel, 6'b010_000);
        end
        tick();
        n_cmp++;
        if (mem_cnt !== 8'd2 || wb_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL load_in_mem_count got mem=%0d wb=%0d want 2/2", mem_cnt, wb_cnt);
        end
        set_nop();
    endtask

    task automatic test_x0();
        set_nop();
        ex_mem = '{rd: 5'd0, reg_write: 1'b1, mem_read: 1'b0};
        mem_wb = '{rd: 5'd0, reg_write: 1'b1, mem_to_reg: 1'b0};
        #1;
        n_cmp++;
        if ({ex_sel, dec_sel} !== 8'b0) begin
            n_err++;
            $display("FAIL x0_sel got %b want %b", {ex_sel, dec_sel}, 8'b0);
        end
        tick();
        n_cmp++;
        if (mem_cnt !== 8'd2 || wb_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL x0_count got mem=%0d wb=%0d want 2/2", mem_cnt, wb_cnt);
        end
        set_nop();
    endtask

    task automatic test_independent();
        set_nop();
        ex_mem = '{rd: 5'd5, reg_write: 1'b1, mem_read: 1'b0};
        mem_wb = '{rd: 5'd6, reg_write: 1'b1, mem_to_reg: 1'b1};
        id_ex  = '{rs1: 5'd5, rs2: 5'd6};
        #1;
        n_cmp++;
        if (ex_sel !== 6'b100_001) begin
            n_err++;
            $display("FAIL independent_sel got %b want %b", ex_sel, 6'b100_001);
        end
        tick();
        n_cmp++;
        if (mem_cnt !== 8'd3 || wb_cnt !== 8'd3) begin
            n_err++;
            $display("FAIL independent_count got mem=%0d wb=%0d want 3/3", mem_cnt, wb_cnt);
        end
        set_nop();
    endtask

    task automatic test_decode();
        set_nop();
        mem_wb  = '{rd: 5'd9, reg_write: 1'b1, mem_to_reg: 1'b0};
        dec_rs1 = 5'd4;
        dec_rs2 = 5'd9;
        #1;
        n_cmp++;
        if (dec_sel !== 2'b01) begin
            n_err++;
            $display("FAIL decode_hit got %b want %b", dec_sel, 2'b01);
        end
        n_cmp++;
        if (ex_sel !== 6'b0) begin
            n_err++;
            $display("FAIL decode_ex_quiet got %b want %b", ex_sel, 6'b0);
        end
        dec_rs1 = 5'd9;
        #1;
        n_cmp++;
        if (dec_sel !== 2'b11) begin
            n_err++;
            $display("FAIL decode_both got %b want %b", dec_sel, 2'b11);
        end
        mem_wb.reg_write = 1'b0;
        #1;
        n_cmp++;
        if (dec_sel !== 2'b00) begin
            n_err++;
            $display("FAIL decode_no_write got %b want %b", dec_sel, 2'b00);
        end
        mem_wb.reg_write = 1'b1;
        tick();
        n_cmp++;
        if (mem_cnt !== 8'd3 || wb_cnt !== 8'd3) begin
            n_err++;
            $display("FAIL decode_not_counted got mem=%0d wb=%0d want 3/3", mem_cnt, wb_cnt);
        end
        set_nop();
    endtask

    task automatic test_saturation();
        set_nop();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        // WB ALU hit on both operands: +2 per edge.
        mem_wb = '{rd: 5'd4, reg_write: 1'b1, mem_to_reg: 1'b0};
        id_ex  = '{rs1: 5'd4, rs2: 5'd4};
        for (int i = 0; i < 127; i++) tick();
        n_cmp++;
        if (wb_cnt !== 8'd254) begin
            n_err++;
            $display("FAIL wb_near_full got %0d want %0d", wb_cnt, 254);
        end
        tick();
        n_cmp++;
        if (wb_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL wb_saturate got %0d want %0d", wb_cnt, 255);
        end
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (wb_cnt !== 8'd255 || mem_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL wb_hold got wb=%0d mem=%0d want 255/0", wb_cnt, mem_cnt);
        end
        // MEM hit on both operands: +2 per edge.
        set_nop();
        ex_mem = '{rd: 5'd5, reg_write: 1'b1, mem_read: 1'b0};
        id_ex  = '{rs1: 5'd5, rs2: 5'd5};
        for (int i = 0; i < 127; i++) tick();
        n_cmp++;
        if (mem_cnt !== 8'd254) begin
            n_err++;
            $display("FAIL mem_near_full got %0d want %0d", mem_cnt, 254);
        end
        for (int i = 0; i < 3; i++) tick();
        n_cmp++;
        if (mem_cnt !== 8'd255 || wb_cnt !== 8'd255) begin
            n_err++;
            $display("FAIL mem_saturate got mem=%0d wb=%0d want 255/255", mem_cnt, wb_cnt);
        end
        set_nop();
    endtask

    task automatic test_reset_mid();
        set_nop();
        ex_mem = '{rd: 5'd5, reg_write: 1'b1, mem_read: 1'b0};
        mem_wb = '{rd: 5'd4, reg_write: 1'b1, mem_to_reg: 1'b0};
        id_ex  = '{rs1: 5'd5, rs2: 5'd4};
        reset  = 1'b1;
        #1;
        n_cmp++;
        if (ex_sel !== 6'b100_010) begin
            n_err++;
            $display("FAIL reset_mid_sel got %b want %b", ex_sel, 6'b100_010);
        end
        tick();
        n_cmp++;
        if (mem_cnt !== 8'd0 || wb_cnt !== 8'd0) begin
            n_err++;
            $display("FAIL reset_mid_clear got mem=%0d wb=%0d want 0/0", mem_cnt, wb_cnt);
        end
        reset = 1'b0;
        id_ex = '{rs1: 5'd4, rs2: 5'd5};
        #1;
        n_cmp++;
        if (ex_sel !== 6'b010_100) begin
            n_err++;
            $display("FAIL reset_mid_follow got %b want %b", ex_sel, 6'b010_100);
        end
        tick();
        tick();
        n_cmp++;
        if (mem_cnt !== 8'd2 || wb_cnt !== 8'd2) begin
            n_err++;
            $display("FAIL reset_mid_resume got mem=%0d wb=%0d want 2/2", mem_cnt, wb_cnt);
        end
        set_nop();
    endtask

    initial begin
        reset = 1'b1;
        set_nop();
        test_reset();
        test_mem_priority();
        test_load();
        test_x0();
        test_independent();
        test_decode();
        test_saturation();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/bypass_unit.md
Name: bypass_unit

Overview:
- Combinational RAW-forwarding select generator for the 5-stage RISC-V pipeline.
- Compares the EX-stage source registers against the destinations of instructions in MEM (ex_mem) and WB (mem_wb).
- Compares the decode-stage source registers against WB for same-cycle register-file write/read bypass.
- Drives the EX operand muxes and the decode operand muxes; also keeps two saturating performance counters of bypass events.

Parameters:
- REG_AW, 5, register index width.
- CNT_W, 32, performance counter width.

Ports:
- clock  in  1  system clock; used by the counters only.
- reset  in  1  synchronous, active-high.
- id_ex_bus_in  in  id_ex_bus_t  EX-stage instruction; uses fields rs1, rs2.
- ex_mem_bus_in  in  ex_mem_bus_t  MEM-stage instruction; uses fields rd, reg_write, mem_read.
- mem_wb_bus_in  in  mem_wb_bus_t  WB-stage instruction; uses fields rd, reg_write, mem_to_reg.
- dec_rs1  in  REG_AW  decode-stage rs1 index.
- dec_rs2  in  REG_AW  decode-stage rs2 index.
- bypassAfromMEM, bypassBfromMEM  out  1  forward the MEM-stage ALU result to EX operand A/B.
- bypassAfromALUinWB, bypassBfromALUinWB  out  1  forward the WB-stage ALU result to A/B.
- bypassAfromLDinWB, bypassBfromLDinWB  out  1  forward the WB-stage load data to A/B.
- bypassDecodeAfromWB, bypassDecodeBfromWB  out  1  forward the WB write data to the decode operand.
- fwd_mem_count  out  CNT_W  operands forwarded from MEM since reset.
- fwd_wb_count  out  CNT_W  operands forwarded from WB since reset.

Behaviour:
- All bypass outputs are purely combinational from the current inputs; zero latency.
- memHit(s) = ex_mem.reg_write & ex_mem.rd != 0 & ex_mem.rd == s & !ex_mem.mem_read.
  - Loads in MEM are never forwarded; the load-use stall is owned by the hazard unit.
- wbHit(s) = mem_wb.reg_write & mem_wb.rd != 0 & mem_wb.rd == s.
- For X in {A,B}, with s = id_ex.rs1 for A and id_ex.rs2 for B:
  - bypassXfromMEM = memHit(s).
  - bypassXfromALUinWB = wbHit(s) & !mem_wb.mem_to_reg & !memHit(s).
  - bypassXfromLDinWB = wbHit(s) & mem_wb.mem_to_reg & !memHit(s).
- MEM has priority over WB because it holds the younger value. At most one of the three selects per operand is high; all zero means use the register-file value.
- If MEM holds a load to the same rd and WB also matches, the WB select is asserted.
  - This path is reachable only if the hazard unit failed to stall; it is still defined.
- bypassDecodeAfromWB = wbHit(dec_rs1); bypassDecodeBfromWB = wbHit(dec_rs2).
- x0 is never forwarded. rs == 0 means every select for that operand is 0.
- A and B are evaluated independently; rs1 == rs2 may assert both.
- Counters are registered on the rising clock edge:
  - fwd_mem_count += bypassAfromMEM + bypassBfromMEM, giving increments of 0, 1 or 2.
  - fwd_wb_count += the four WB EX-select bits. Decode bypasses are not counted.
  - Both counters saturate at all-ones and never wrap, including when +2 would overflow.
- On reset, both counters are 0 on the next edge; reset overrides any increment in that cycle.
- The bypass outputs do not depend on reset. During reset they reflect the inputs, which are NOPs with reg_write = 0 and therefore give all-zero selects.

Optional Feature:
- BYPASS_ASSERT_EN defined: simulation-only immediate assertions, evaluated each clock edge while reset is low.
  - Per operand, the three EX selects are one-hot-or-zero.
  - No select is asserted when its source index is 0.
  - Any violation calls $error with the time and both rd fields.
- Undefined: no assertion code is compiled. Functional behaviour is identical either way.

Decomposition:
- Shared package (pipeline package): id_ex_bus_t, ex_mem_bus_t, mem_wb_bus_t with the fields listed above, and the REG_AW constant.
- One natural sub-module, bypass_operand_sel.
  - Inputs: a source index plus the MEM and WB match fields.
  - Outputs: the three one-hot selects.
  - Instantiated twice, for A and B.
- Decode hits and counters stay in the top module.

Test Plan:
- MEM ALU rd=5 reg_write=1, WB rd=5 ALU, EX rs1=5 rs2=5 -> bypassAfromMEM=1 and bypassBfromMEM=1, all WB selects 0; fwd_mem_count goes 0->2 after one edge.
- MEM rd=7 mem_read=1, WB rd=3 load (mem_to_reg=1), EX rs1=7 rs2=3 -> all A selects 0; bypassBfromLDinWB=1.
- rd=0 with reg_write=1 in both MEM and WB, EX rs1=rs2=0, dec_rs1=0 -> every bypass output 0 and counters unchanged.
- WB rd=9 ALU reg_write=1, dec_rs2=9, dec_rs1=4 -> bypassDecodeBfromWB=1, bypassDecodeAfromWB=0; with reg_write=0 both are 0.
- Preload fwd_wb_count to all-ones minus 1 via the bench (run until close), then assert WB ALU hits on both operands -> count is all-ones and holds there on later hits.
- Drive hits and assert reset for one cycle mid-run -> both counters are 0 after that edge; bypass outputs keep following the inputs combinationally throughout.
